decode_unit: RTL

RV32I instruction decode stage: registers one fetched instruction per handshake and produces the ALU control fields (op, sub, arithmetic shift, branch op), register indices, the sign-extended immediate and instruction-class flags. It is the producer for the ALU's control inputs and sits between fetch and execute as a single valid/ready pipeline register, with flush support for taken branches and jumps.

---
 rtl/decode_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/decode_unit.sv
// RV32I decode pipeline register: one instruction per valid/ready handshake, 1-cycle latency.
// o_ready falls while a held bundle is stalled by i_ready or while i_flush discards the stage.
module decode_unit (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_pc,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd,
   output logic [31:0] o_imm,
   output logic [2:0]  o_alu_op,
   output logic        o_alu_sub,
   output logic        o_alu_arith_shift,
   output logic [2:0]  o_branch_op,
   output logic        o_use_imm,
   output logic        o_use_pc,
   output logic        o_reg_write,
   output logic        o_is_branch,
   output logic        o_is_jal,
   output logic        o_is_jalr,
   output logic        o_is_load,
   output logic        o_is_store,
   output logic [2:0]  o_mem_funct3,
   output logic        o_illegal
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  alu_op;
      logic        alu_sub;
      logic        alu_arith;
      logic [2:0]  branch_op;
      logic        use_imm;
      logic        use_pc;
      logic        reg_write;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        is_load;
      logic        is_store;
      logic [2:0]  mem_funct3;
      logic        illegal;
   } bundle_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        accept;
   bundle_t     dec;
   bundle_t     bundle_d, bundle_q;
   logic        valid_d, valid_q;

   assign opcode = i_instr[6:0];
   assign funct3 = i_instr[14:12];
   assign funct7 = i_instr[31:25];

   assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign imm_u = {i_instr[31:12], 12'h000};
   assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      dec            = '0;
      dec.pc         = i_pc;
      dec.rs1        = i_instr[19:15];
      dec.rs2        = i_instr[24:20];
      dec.rd         = i_instr[11:7];
      dec.mem_funct3 = funct3;
      dec.branch_op  = 3'b010;
      unique case (opcode)
         OPC_OP: begin
            dec.alu_op    = funct3;
            dec.reg_write = 1'b1;
            if (funct7 == F7_ALT) begin
               dec.alu_sub   = (funct3 == 3'b000);
               dec.alu_arith = (funct3 == 3'b101);
               dec.illegal   = (funct3 != 3'b000) && (funct3 != 3'b101);
            end else begin
               dec.illegal = (funct7 != F7_ZERO);
            end
         end
         OPC_OP_IMM: begin
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.alu_op    = funct3;
            dec.reg_write = 1'b1;
            // Only the shift encodings constrain the upper immediate bits.
            if (funct3 == 3'b001) begin
               dec.illegal = (funct7 != F7_ZERO);
            end else if (funct3 == 3'b101) begin
               dec.alu_arith = i_instr[30];
               dec.illegal   = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
         end
         OPC_LUI: begin
            dec.imm       = imm_u;
            dec.rs1       = 5'd0;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm       = imm_u;
            dec.use_pc    = 1'b1;
            dec.use_imm   = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.imm       = imm_j;
            dec.is_jal    = 1'b1;
            dec.reg_write = 1'b1;
         end
         OPC_JALR: begin
            dec.imm       = imm_i;
            dec.is_jalr   = 1'b1;
            dec.reg_write = 1'b1;
            dec.illegal   = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.imm       = imm_b;
            dec.is_branch = 1'b1;
            dec.branch_op = funct3;
            dec.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LOAD: begin
            dec.imm       = imm_i;
            dec.use_imm   = 1'b1;
            dec.is_load   = 1'b1;
            dec.reg_write = 1'b1;
            dec.illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            dec.imm      = imm_s;
            dec.use_imm  = 1'b1;
            dec.is_store = 1'b1;
            dec.illegal  = (funct3 > 3'b010);
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      // An illegal encoding must never produce an architectural side effect downstream.
      if (dec.illegal) begin
         dec.reg_write = 1'b0;
         dec.is_load   = 1'b0;
         dec.is_store  = 1'b0;
         dec.is_branch = 1'b0;
         dec.is_jal    = 1'b0;
         dec.is_jalr   = 1'b0;
      end
      if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end
   end

   assign o_ready = (!valid_q || i_ready) && !i_flush;
   assign accept  = i_valid && o_ready;

   always_comb begin
      valid_d  = valid_q;
      bundle_d = bundle_q;
      if (accept) begin
         valid_d  = 1'b1;
         bundle_d = dec;
      end else if (i_flush || (valid_q && i_ready)) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q  <= 1'b0;
         bundle_q <= '0;
      end else begin
         valid_q  <= valid_d;
         bundle_q <= bundle_d;
      end
   end

   assign o_valid           = valid_q;
   assign o_pc              = bundle_q.pc;
   assign o_rs1             = bundle_q.rs1;
   assign o_rs2             = bundle_q.rs2;
   assign o_rd              = bundle_q.rd;
   assign o_imm             = bundle_q.imm;
   assign o_alu_op          = bundle_q.alu_op;
   assign o_alu_sub         = bundle_q.alu_sub;
   assign o_alu_arith_shift = bundle_q.alu_arith;
   assign o_branch_op       = bundle_q.branch_op;
   assign o_use_imm         = bundle_q.use_imm;
   assign o_use_pc          = bundle_q.use_pc;
   assign o_reg_write       = bundle_q.reg_write;
   assign o_is_branch       = bundle_q.is_branch;
   assign o_is_jal          = bundle_q.is_jal;
   assign o_is_jalr         = bundle_q.is_jalr;
   assign o_is_load         = bundle_q.is_load;
   assign o_is_store        = bundle_q.is_store;
   assign o_mem_funct3      = bundle_q.mem_funct3;
   assign o_illegal         = bundle_q.illegal;

endmodule
